// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the encoder and the decoder: instr_type codes,
// opcode/funct fields, instruction-format enum, type resolution and immediate-range helpers.
package rv_isa_pkg;

  localparam int WIDTH            = 32;
  localparam int REG_WIDTH        = 5;
  localparam int INSTR_TYPE_WIDTH = 8;

  localparam logic [7:0] T_LUI   = 8'd6;
  localparam logic [7:0] T_AUIPC = 8'd7;
  localparam logic [7:0] T_JAL   = 8'd8;
  localparam logic [7:0] T_JALR  = 8'd9;
  localparam logic [7:0] T_BEQ   = 8'd10;
  localparam logic [7:0] T_BNE   = 8'd11;
  localparam logic [7:0] T_BLT   = 8'd12;
  localparam logic [7:0] T_BGE   = 8'd13;
  localparam logic [7:0] T_BLTU  = 8'd14;
  localparam logic [7:0] T_BGEU  = 8'd15;
  localparam logic [7:0] T_ADDI  = 8'd16;
  localparam logic [7:0] T_SLTI  = 8'd17;
  localparam logic [7:0] T_SLTIU = 8'd18;
  localparam logic [7:0] T_XORI  = 8'd19;
  localparam logic [7:0] T_ORI   = 8'd20;
  localparam logic [7:0] T_ANDI  = 8'd21;
  localparam logic [7:0] T_SLLI  = 8'd22;
  localparam logic [7:0] T_SRLI  = 8'd23;
  localparam logic [7:0] T_SRAI  = 8'd24;
  localparam logic [7:0] T_ADD   = 8'd25;
  localparam logic [7:0] T_SUB   = 8'd26;
  localparam logic [7:0] T_SLL   = 8'd27;
  localparam logic [7:0] T_SLT   = 8'd28;
  localparam logic [7:0] T_SLTU  = 8'd29;
  localparam logic [7:0] T_XOR   = 8'd30;
  localparam logic [7:0] T_SRL   = 8'd31;
  localparam logic [7:0] T_SRA   = 8'd32;
  localparam logic [7:0] T_OR    = 8'd33;
  localparam logic [7:0] T_AND   = 8'd34;
  localparam logic [7:0] T_LOAD  = 8'd35;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0]  F7_ZERO  = 7'b0000000;
  localparam logic [6:0]  F7_ALT   = 7'b0100000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  typedef struct packed {
    fmt_e       fmt;
    logic       shift;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       known;
  } dec_t;

  function automatic dec_t resolve(input logic [7:0] t);
    dec_t d;
    d.fmt    = FMT_I;
    d.shift  = 1'b0;
    d.opcode = OP_IMM;
    d.f3     = 3'b000;
    d.f7     = F7_ZERO;
    d.known  = 1'b1;
    case (t)
      T_LUI:   begin d.fmt = FMT_U; d.opcode = OP_LUI;   end
      T_AUIPC: begin d.fmt = FMT_U; d.opcode = OP_AUIPC; end
      T_JAL:   begin d.fmt = FMT_J; d.opcode = OP_JAL;   end
      T_JALR:  begin d.opcode = OP_JALR; d.f3 = F3_JALR; end
      T_BEQ:   begin d.fmt = FMT_B; d.opcode = OP_BRANCH; d.f3 = F3_BEQ;  end
      T_BNE:   begin d.fmt = FMT_B; d.opcode = OP_BRANCH; d.f3 = F3_BNE;  end
      T_BLT:   begin d.fmt = FMT_B; d.opcode = OP_BRANCH; d.f3 = F3_BLT;  end
      T_BGE:   begin d.fmt = FMT_B; d.opcode = OP_BRANCH; d.f3 = F3_BGE;  end
      T_BLTU:  begin d.fmt = FMT_B; d.opcode = OP_BRANCH; d.f3 = F3_BLTU; end
      T_BGEU:  begin d.fmt = FMT_B; d.opcode = OP_BRANCH; d.f3 = F3_BGEU; end
      T_ADDI:  d.f3 = F3_ADD;
      T_SLTI:  d.f3 = F3_SLT;
      T_SLTIU: d.f3 = F3_SLTU;
      T_XORI:  d.f3 = F3_XOR;
      T_ORI:   d.f3 = F3_OR;
      T_ANDI:  d.f3 = F3_AND;
      T_SLLI:  begin d.shift = 1'b1; d.f3 = F3_SLL; end
      T_SRLI:  begin d.shift = 1'b1; d.f3 = F3_SR;  end
      T_SRAI:  begin d.shift = 1'b1; d.f3 = F3_SR; d.f7 = F7_ALT; end
      T_ADD:   begin d.fmt = FMT_R; d.opcode = OP_REG; d.f3 = F3_ADD;  end
      T_SUB:   begin d.fmt = FMT_R; d.opcode = OP_REG; d.f3 = F3_ADD; d.f7 = F7_ALT; end
      T_SLL:   begin d.fmt = FMT_R; d.opcode = OP_REG; d.f3 = F3_SLL;  end
      T_SLT:   begin d.fmt = FMT_R; d.opcode = OP_REG; d.f3 = F3_SLT;  end
      T_SLTU:  begin d.fmt = FMT_R; d.opcode = OP_REG; d.f3 = F3_SLTU; end
      T_XOR:   begin d.fmt = FMT_R; d.opcode = OP_REG; d.f3 = F3_XOR;  end
      T_SRL:   begin d.fmt = FMT_R; d.opcode = OP_REG; d.f3 = F3_SR;   end
      T_SRA:   begin d.fmt = FMT_R; d.opcode = OP_REG; d.f3 = F3_SR; d.f7 = F7_ALT; end
      T_OR:    begin d.fmt = FMT_R; d.opcode = OP_REG; d.f3 = F3_OR;   end
      T_AND:   begin d.fmt = FMT_R; d.opcode = OP_REG; d.f3 = F3_AND;  end
      T_LOAD:  begin d.opcode = OP_LOAD; d.f3 = F3_LW; end
      default: d.known = 1'b0;
    endcase
    return d;
  endfunction

  // True when imm survives the format's field truncation unchanged.
  function automatic logic imm_fits(input fmt_e fmt, input logic shift, input logic [31:0] imm);
    logic ok;
    ok = 1'b1;
    case (fmt)
      FMT_I:   ok = shift ? (imm[31:5] == 27'd0) : (imm[31:11] == {21{imm[11]}});
      FMT_S:   ok = (imm[31:11] == {21{imm[11]}});
      FMT_B:   ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
      FMT_J:   ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
      FMT_U:   ok = (imm[11:0] == 12'd0);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bus of instr_encoder. Both sides use valid/ready: a transfer happens on the
// rising clk edge where valid && ready; once valid is raised, it and its payload hold until that edge.
interface instr_encoder_if;
  import rv_isa_pkg::*;

  logic                        in_valid;
  logic                        in_ready;
  logic [INSTR_TYPE_WIDTH-1:0] in_type;
  logic [REG_WIDTH-1:0]        in_rd;
  logic [REG_WIDTH-1:0]        in_rs1;
  logic [REG_WIDTH-1:0]        in_rs2;
  logic [WIDTH-1:0]            in_imm;
  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH-1:0]            out_inst;
  logic                        out_err;
  logic [7:0]                  err_count;

  modport slave (
    input  in_valid, in_type, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err, err_count
  );

  modport master (
    output in_valid, in_type, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err, err_count
  );
endinterface

// File: rtl/instr_imm_pack.sv
// Places immediate bits into their RV32I bit positions for a given format; all other bits are zero.
module instr_imm_pack
  import rv_isa_pkg::*;
(
  input  fmt_e        fmt,
  input  logic        shift,
  input  logic [31:0] imm,
  output logic [31:0] field
);

  always_comb begin
    field = '0;
    case (fmt)
      FMT_I:   field = shift ? {7'b0, imm[4:0], 20'b0} : {imm[11:0], 20'b0};
      FMT_S:   field = {imm[11:5], 13'b0, imm[4:0], 7'b0};
      FMT_B:   field = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
      FMT_U:   field = {imm[31:12], 12'b0};
      FMT_J:   field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
      default: field = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder: S1 resolves format/opcode/funct, S2 packs and holds the word.
// Define ENC_RANGE_CHECK_EN to also flag immediates that do not fit their format.
module instr_encoder
  import rv_isa_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  instr_encoder_if.slave bus
);

  dec_t        in_dec;
  logic        in_err;
  logic        s1_valid;
  dec_t        s1_dec;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [31:0] s1_imm;
  logic        s1_err;
  logic        s1_adv;
  logic        s2_adv;
  logic [31:0] imm_field;
  logic [31:0] word;

  assign s2_adv       = !bus.out_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  assign in_dec = resolve(bus.in_type);

`ifdef ENC_RANGE_CHECK_EN
  assign in_err = !in_dec.known || !imm_fits(in_dec.fmt, in_dec.shift, bus.in_imm);
`else
  assign in_err = !in_dec.known;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_dec   <= '0;
      s1_rd    <= '0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_imm   <= '0;
      s1_err   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_dec <= in_dec;
        s1_rd  <= bus.in_rd;
        s1_rs1 <= bus.in_rs1;
        s1_rs2 <= bus.in_rs2;
        s1_imm <= bus.in_imm;
        s1_err <= in_err;
      end
    end
  end

  instr_imm_pack u_imm_pack (
    .fmt   (s1_dec.fmt),
    .shift (s1_dec.shift),
    .imm   (s1_imm),
    .field (imm_field)
  );

  // Register fields a format does not carry stay zero so decode(encode(x)) sees clean words.
  always_comb begin
    word = imm_field | {25'b0, s1_dec.opcode};
    if (s1_dec.fmt == FMT_R || s1_dec.shift)
      word = word | {s1_dec.f7, 25'b0};
    if (s1_dec.fmt inside {FMT_R, FMT_S, FMT_B})
      word = word | {7'b0, s1_rs2, 20'b0};
    if (s1_dec.fmt inside {FMT_R, FMT_I, FMT_S, FMT_B})
      word = word | {12'b0, s1_rs1, 3'b0, 12'b0} | {17'b0, s1_dec.f3, 12'b0};
    if (s1_dec.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J})
      word = word | {20'b0, s1_rd, 7'b0};
    if (!s1_dec.known)
      word = NOP_WORD;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.out_valid <= 1'b0;
      bus.out_inst  <= '0;
      bus.out_err   <= 1'b0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_inst <= word;
        bus.out_err  <= s1_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      bus.err_count <= '0;
    else if (bus.out_valid && bus.out_ready && bus.out_err && bus.err_count != 8'hFF)
      bus.err_count <= bus.err_count + 8'd1;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed RV32I vectors, backpressure, mid-flight reset,
// randomized traffic and err_count saturation against a mnemonic-level encoding model.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if bus();

  instr_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef ENC_RANGE_CHECK_EN
  localparam logic EXP_RANGE = 1'b1;
`else
  localparam logic EXP_RANGE = 1'b0;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] exp_q[$];
  int          exp_cnt = 0;
  int          acc_cnt = 0;
  int          ready_mode = 1;

  // ---------------- reference model: {err, word} straight from the RV32I tables
  function automatic logic [32:0] model(input logic [7:0] t, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm);
    logic [31:0] w;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        known;
    logic        range_bad;
    longint      sv;
    sv        = longint'($signed(imm));
    w         = 32'h0000_0013;
    f3        = 3'd0;
    f7        = 7'd0;
    known     = 1'b1;
    range_bad = 1'b0;
    if (t == 8'd6 || t == 8'd7) begin
      w = {imm[31:12], rd, (t == 8'd6) ? 7'h37 : 7'h17};
      range_bad = (imm[11:0] != 12'd0);
    end else if (t == 8'd8) begin
      w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
      range_bad = sv < -1048576 || sv > 1048575 || imm[0];
    end else if (t == 8'd9) begin
      w = {imm[11:0], rs1, 3'd0, rd, 7'h67};
      range_bad = sv < -2048 || sv > 2047;
    end else if (t >= 8'd10 && t <= 8'd15) begin
      case (t)
        8'd10: f3 = 3'd0;  8'd11: f3 = 3'd1;  8'd12: f3 = 3'd4;
        8'd13: f3 = 3'd5;  8'd14: f3 = 3'd6;  default: f3 = 3'd7;
      endcase
      w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
      range_bad = sv < -4096 || sv > 4095 || imm[0];
    end else if (t >= 8'd16 && t <= 8'd21) begin
      case (t)
        8'd16: f3 = 3'd0;  8'd17: f3 = 3'd2;  8'd18: f3 = 3'd3;
        8'd19: f3 = 3'd4;  8'd20: f3 = 3'd6;  default: f3 = 3'd7;
      endcase
      w = {imm[11:0], rs1, f3, rd, 7'h13};
      range_bad = sv < -2048 || sv > 2047;
    end else if (t >= 8'd22 && t <= 8'd24) begin
      w = {(t == 8'd24) ? 7'h20 : 7'h00, imm[4:0], rs1, (t == 8'd22) ? 3'd1 : 3'd5, rd, 7'h13};
      range_bad = imm > 32'd31;
    end else if (t >= 8'd25 && t <= 8'd34) begin
      case (t)
        8'd25, 8'd26: f3 = 3'd0;  8'd27: f3 = 3'd1;  8'd28: f3 = 3'd2;
        8'd29: f3 = 3'd3;  8'd30: f3 = 3'd4;  8'd31, 8'd32: f3 = 3'd5;
        8'd33: f3 = 3'd6;  default: f3 = 3'd7;
      endcase
      f7 = (t == 8'd26 || t == 8'd32) ? 7'h20 : 7'h00;
      w = {f7, rs2, rs1, f3, rd, 7'h33};
    end else if (t == 8'd35) begin
      w = {imm[11:0], rs1, 3'd2, rd, 7'h03};
      range_bad = sv < -2048 || sv > 2047;
    end else begin
      known = 1'b0;
    end
`ifdef ENC_RANGE_CHECK_EN
    return {!known || range_bad, w};
`else
    return {!known, w};
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- out_ready driver (single owner)
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- scoreboard / compare process
  logic        hold_v = 1'b0;
  logic [32:0] hold_w;
  always @(negedge clk) begin
    logic [32:0] w;
    if (!reset) begin
      hold_v = 1'b0;
    end else begin
      check("err_count", 64'(bus.err_count), 64'(exp_cnt));
      check("in_ready", 64'(bus.in_ready), 64'((exp_q.size() < 2) || bus.out_ready));
      if (hold_v)
        check("out_hold", 64'({bus.out_valid, bus.out_err, bus.out_inst}), 64'({1'b1, hold_w}));
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_type, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm));
        acc_cnt++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(bus.out_inst), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          check("out_word", 64'({bus.out_err, bus.out_inst}), 64'(w));
          if (w[32] && exp_cnt < 255) exp_cnt++;
        end
        hold_v = 1'b0;
      end else begin
        hold_v = bus.out_valid;
        hold_w = {bus.out_err, bus.out_inst};
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1)
  task automatic send(input logic [7:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int g;
    g = 0;
    bus.in_valid = 1'b1;
    bus.in_type  = t;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
    do begin
      @(negedge clk);
      g++;
    end while (!bus.in_ready && g < 200);
    if (!bus.in_ready) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [31:0] inst, input logic err);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!bus.out_valid && g < 50);
    if (!bus.out_valid) begin
      check({name, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check({name, "_inst"}, 64'(bus.out_inst), 64'(inst));
      check({name, "_err"}, 64'(bus.out_err), 64'(err));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  t;
    logic [31:0] imm;
    int          acc0;
    int          nv;
    bus.in_valid = 1'b0;
    bus.in_type  = '0;
    bus.in_rd    = '0;
    bus.in_rs1   = '0;
    bus.in_rs2   = '0;
    bus.in_imm   = '0;

    // reset state
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_inst",  64'(bus.out_inst),  64'd0);
    check("rst_out_err",   64'(bus.out_err),   64'd0);
    check("rst_err_count", 64'(bus.err_count), 64'd0);
    #21 reset = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

    // pin the model to hand-encoded words
    check("pin_addi", 64'(model(8'd16, 5'd1, 5'd2, 5'd0, 32'd5)), 64'({1'b0, 32'h00510093}));
    check("pin_add",  64'(model(8'd25, 5'd3, 5'd1, 5'd2, 32'd0)), 64'({1'b0, 32'h002081B3}));
    check("pin_sub",  64'(model(8'd26, 5'd3, 5'd1, 5'd2, 32'd0)), 64'({1'b0, 32'h402081B3}));
    check("pin_beq",  64'(model(8'd10, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC)), 64'({1'b0, 32'hFE208EE3}));
    check("pin_lui",  64'(model(8'd6, 5'd5, 5'd0, 5'd0, 32'h12345000)), 64'({1'b0, 32'h123452B7}));
    check("pin_jal",  64'(model(8'd8, 5'd1, 5'd0, 5'd0, 32'd8)), 64'({1'b0, 32'h008000EF}));
    check("pin_bad",  64'(model(8'hFF, 5'd1, 5'd2, 5'd3, 32'd9)), 64'({1'b1, 32'h00000013}));
    check("pin_range", 64'(model(8'd16, 5'd1, 5'd2, 5'd0, 32'h800)), 64'({EXP_RANGE, 32'h80010093}));

    // latency: captured at edge E, visible after edge E+1; unused rs2 must not leak
    send(8'd16, 5'd1, 5'd2, 5'd7, 32'd5);
    check("lat_not_yet", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_valid", 64'(bus.out_valid), 64'd1);
    check("lat_inst", 64'(bus.out_inst), 64'h00510093);
    check("lat_err", 64'(bus.out_err), 64'd0);
    @(posedge clk); #1;

    send(8'd25, 5'd3, 5'd1, 5'd2, 32'hDEAD);       wait_out("add", 32'h002081B3, 1'b0);
    send(8'd26, 5'd3, 5'd1, 5'd2, 32'd0);          wait_out("sub", 32'h402081B3, 1'b0);
    send(8'd10, 5'd9, 5'd1, 5'd2, 32'hFFFFFFFC);   wait_out("beq", 32'hFE208EE3, 1'b0);
    send(8'd6, 5'd5, 5'd3, 5'd4, 32'h12345000);    wait_out("lui", 32'h123452B7, 1'b0);
    send(8'd8, 5'd1, 5'd6, 5'd7, 32'd8);           wait_out("jal", 32'h008000EF, 1'b0);
    check("errcnt_before", 64'(bus.err_count), 64'd0);
    send(8'hFF, 5'd1, 5'd2, 5'd3, 32'd1);          wait_out("unknown", 32'h00000013, 1'b1);
    check("errcnt_after", 64'(bus.err_count), 64'd1);
    send(8'd16, 5'd1, 5'd2, 5'd0, 32'h800);        wait_out("addi_800", 32'h80010093, EXP_RANGE);

    // backpressure: 4 pushes against a stalled consumer
    ready_mode = 0;
    @(posedge clk); #1;
    acc0 = acc_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) send(8'd16, 5'd1, 5'd2, 5'd0, 32'(i + 100));
      end
      begin
        repeat (4) @(negedge clk);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_accepted", 64'(acc_cnt - acc0), 64'd2);
        #1 ready_mode = 1;
      end
    join
    drain("bp");

    // mid-flight reset with two words held
    ready_mode = 0;
    @(posedge clk); #1;
    send(8'd25, 5'd1, 5'd2, 5'd3, 32'd0);
    send(8'hFF, 5'd4, 5'd5, 5'd6, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("rst_flush_valid", 64'(bus.out_valid), 64'd0);
    check("rst_flush_errcnt", 64'(bus.err_count), 64'd0);
    exp_q.delete();
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    ready_mode = 1;
    nv = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) nv++;
    end
    check("rst_no_emit", 64'(nv), 64'd0);
    @(posedge clk); #1;

    // randomized traffic with random consumer stalls
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) t = 8'($urandom_range(0, 255));
      else t = 8'($urandom_range(6, 35));
      case ($urandom_range(0, 3))
        0:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1:       imm = $urandom;
        2:       imm = 32'($urandom_range(0, 31));
        default: imm = $urandom & 32'hFFFFF000;
      endcase
      if ($urandom_range(0, 1) == 1) imm[0] = 1'b0;
      send(t, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), imm);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    ready_mode = 1;
    drain("rand");

    // err_count saturation
    for (int i = 0; i < 260; i++) send(8'hFF, 5'd0, 5'd0, 5'd0, 32'(i));
    drain("sat");
    check("errcnt_saturated", 64'(bus.err_count), 64'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
